seq_multiplier: RTL and testbench

//  Iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.

---
 rtl/seq_multiplier.sv | 134 +++++++++++++
 tb/tb_seq_multiplier.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits.
//   Each operation is independently signed (two's complement) or unsigned.
//   An accepted operation spends WIDTH cycles in BUSY, one partial-product
//   step per cycle, then holds the product in DONE until the consumer takes it.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous reset, active-high
//   in_valid   in   1        a / b / is_signed are valid
//   in_ready   out  1        unit is idle and can accept an operation
//   a          in   WIDTH    multiplicand
//   b          in   WIDTH    multiplier
//   is_signed  in   1        1: operands are two's complement, 0: unsigned
//   out_valid  out  1        prod is valid
//   out_ready  in   1        consumer accepts prod
//   prod       out  2*WIDTH  product (two's complement in signed mode)
//   busy       out  1        an operation is in flight
// -----------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2*WIDTH-1:0]       prod_q, prod_d;

  logic signed [WIDTH:0]    hi_q, hi_d;
  logic signed [WIDTH:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]         lo_q, lo_d;
  logic                     sgn_q, sgn_d;

  logic signed [WIDTH:0]    sum;
  logic                     last_step;

  assign last_step = (cnt_q == LAST_STEP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    mcand_d = mcand_q;
    lo_d    = lo_q;
    sgn_d   = sgn_q;
    sum     = hi_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          hi_d    = '0;
          lo_d    = b;
          mcand_d = is_signed ? $signed({a[WIDTH-1], a}) : $signed({1'b0, a});
          sgn_d   = is_signed;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        // In signed mode the multiplier MSB carries weight -2^(WIDTH-1),
        // so its partial product is subtracted instead of added.
        if (lo_q[0]) begin
          sum = (sgn_q && last_step) ? (hi_q - mcand_q) : (hi_q + mcand_q);
        end
        // Arithmetic right shift of {hi,lo} keeps the running partial
        // product sign-correct in signed mode.
        hi_d  = sgn_q ? {sum[WIDTH], sum[WIDTH:1]} : {1'b0, sum[WIDTH:1]};
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          state_d = S_DONE;
          prod_d  = {hi_d[WIDTH-1:0], lo_d};
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  // Working datapath registers; every operation reloads them at accept
  always_ff @(posedge clk) begin
    hi_q    <= hi_d;
    lo_q    <= lo_d;
    mcand_q <= mcand_d;
    sgn_q   <= sgn_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign prod      = prod_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
//   Bench for seq_multiplier. A WIDTH=8 instance takes a table of directed
//   vectors plus hand-written backpressure and reset sequences; a WIDTH=16
//   instance takes randomized traffic scored against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

  localparam int N_OPS     = 2000;
  localparam int CYC_LIMIT = 80000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv8, ir8, s8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        iv16, ir16, s16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int n_chk  = 0;
  int n_fail = 0;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .prod(p8), .busy(busy8)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .is_signed(s16), .out_valid(ov16), .out_ready(or16), .prod(p16), .busy(busy16)
  );

  // Product of two w-bit operands by plain integer arithmetic, truncated to 2w bits
  function automatic logic [63:0] golden(input logic [63:0] a, input logic [63:0] b,
                                         input bit s, input int w);
    longint x, y, p;
    x = longint'(a);
    y = longint'(b);
    if (s && a[w-1]) x = x - (longint'(1) << w);
    if (s && b[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete operation on the 8-bit unit; lat is the cycle index in which
  // out_valid is first seen, counting the accept cycle as 0.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output logic [15:0] p, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!ir8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_op", ir8, 1);
    iv8 = 1'b1; a8 = a; b8 = b; s8 = s;
    @(negedge clk);
    // Scramble operands after accept; the unit must have captured them already
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
    n = 0;
    while (!ov8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", ov8, 1);
    lat = n + 1;
    p   = p8;
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    check("out_valid_drop", ov8, 0);
    check("in_ready_after_op", ir8, 1);
    check("prod_kept_after_op", p8, p);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  logic [31:0] exp_q[$];

  initial begin
    logic [15:0] p;
    int          lat;
    int          n;
    int          accepted, retired, cyc;
    logic        held;
    logic [31:0] held_p;
    logic [63:0] g;

    vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[2] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    vecs[3] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 16'h0000};
    vecs[5] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    vecs[6] = '{8'h80, 8'h7F, 1'b0, 16'h3F80};
    vecs[7] = '{8'h03, 8'h05, 1'b0, 16'h000F};
    vecs[8] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[9] = '{8'h80, 8'h01, 1'b1, 16'hFF80};

    rst = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0; or16 = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_in_ready8", ir8, 1);
    check("rst_out_valid8", ov8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_prod8", p8, 0);
    check("rst_in_ready16", ir16, 1);
    check("rst_out_valid16", ov16, 0);
    check("rst_prod16", p16, 0);
    rst = 1'b0;

    // Directed vectors, including the most-negative signed cases
    for (int i = 0; i < 10; i++) begin
      run_op8(vecs[i].a, vecs[i].b, vecs[i].s, p, lat);
      check($sformatf("vec%0d_prod", i), p, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, 9);
    end

    // Backpressure: foreign in_valid pulses during BUSY/DONE are ignored and
    // the held result stays stable while out_ready is low.
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'h12; b8 = 8'h34; s8 = 1'b0;
    @(negedge clk);
    iv8 = 1'b0;
    check("bp_busy", busy8, 1);
    check("bp_in_ready_busy", ir8, 0);
    n = 0;
    while (!ov8 && n < 100) begin
      iv8 = n[0]; a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1;
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", ov8, 1);
    for (int i = 0; i < 20; i++) begin
      iv8 = ~iv8; a8 = 8'(i); b8 = 8'hA5;
      @(negedge clk);
      check("bp_out_valid_hold", ov8, 1);
      check("bp_in_ready_done", ir8, 0);
      check("bp_prod_hold", p8, 16'h03A8);
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    check("bp_release_out_valid", ov8, 0);
    check("bp_release_busy", busy8, 0);
    check("bp_release_prod", p8, 16'h03A8);

    // Reset during BUSY cycle 4 discards the operation
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'h55; b8 = 8'h77; s8 = 1'b0;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_busy_before", busy8, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", ir8, 1);
    check("mid_rst_out_valid", ov8, 0);
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_prod", p8, 0);
    repeat (12) @(negedge clk);
    check("mid_rst_no_result", ov8, 0);
    run_op8(8'd3, 8'd5, 1'b0, p, lat);
    check("post_rst_prod", p, 16'd15);
    check("post_rst_latency", lat, 9);

    // Randomized 16-bit traffic scored against the arithmetic model
    accepted = 0; retired = 0; cyc = 0; held = 1'b0; held_p = '0;
    while (retired < N_OPS && cyc < CYC_LIMIT) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        check("rand_out_valid_hold", ov16, 1);
        check("rand_prod_hold", p16, held_p);
      end
      iv16 = (accepted < N_OPS) && ($urandom_range(0, 3) != 0);
      a16  = 16'($urandom);
      b16  = 16'($urandom);
      s16  = 1'($urandom_range(0, 1));
      or16 = ($urandom_range(0, 3) != 0);
      if (iv16 && ir16) begin
        g = golden(64'(a16), 64'(b16), s16, 16);
        exp_q.push_back(g[31:0]);
        accepted++;
      end
      held   = ov16 && !or16;
      held_p = p16;
      if (ov16 && or16) begin
        check("rand_result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check($sformatf("rand_prod_op%0d", retired), p16, exp_q.pop_front());
        retired++;
      end
    end
    check("rand_retired", retired, N_OPS);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
